instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the decoupled instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned       FETCH_ADDR_W    = 32;
  localparam int unsigned       FETCH_DATA_W    = 32;
  localparam int unsigned       FETCH_DEPTH_DEF = 4;
  localparam logic [31:0]       RESET_PC_DEF    = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for the prefetch data queue and the request PC-tag queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEF,
  parameter type         T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  T                       din,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a push into a full queue is accepted only when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch front end: credit-limited requests to a multi-cycle instruction
// memory, prefetch queue toward ID, and redirect handling that drains stale responses.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = FETCH_DEPTH_DEF,
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_head;
  logic [CW-1:0]     q_count, outstanding, outstanding_next;
  logic [CW-1:0]     discard, discard_next;
  logic              q_full, q_empty, tag_full, tag_empty;
  logic              req_fire, rsp, push, pop;
  entry_t            rsp_entry, head;

  // the tag queue occupancy is the in-flight request count
  assign mem_req_valid    = (q_count + outstanding < CW'(DEPTH)) & ~q_full & ~tag_full & ~reset;
  assign mem_req_addr     = fetch_pc;
  assign req_fire         = mem_req_valid & mem_req_ready;
  assign rsp              = mem_rsp_valid & ~tag_empty;
  assign push             = rsp & ~redirect_valid & (state == FETCH);
  assign out_valid        = ~q_empty;
  assign pop              = out_valid & out_ready;
  assign out_pc           = q_empty ? '0 : head.pc;
  assign out_instr        = q_empty ? '0 : head.instr;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp);
  assign rsp_entry        = '{pc: tag_head, instr: mem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) data_q (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   (rsp_entry),
    .head  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [ADDR_W-1:0])) tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp),
    .clear (1'b0),
    .din   (fetch_pc),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  always_comb begin
    state_next   = state;
    discard_next = discard;
    if (redirect_valid) begin
      // everything still in flight after this cycle, including a request accepted now, is stale
      discard_next = outstanding_next;
      state_next   = (outstanding_next != '0) ? DRAIN : FETCH;
    end else if (state == DRAIN && rsp) begin
      discard_next = discard - CW'(1);
      if (discard == CW'(1)) state_next = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      discard  <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      if (redirect_valid)  fetch_pc <= redirect_pc;
      else if (req_fire)   fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model with a behavioural memory.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // behavioural instruction memory: in-order, latency lat_min..lat_min+lat_jit
  typedef struct {logic [31:0] addr; int unsigned due;} pend_t;
  pend_t       pend[$];
  int unsigned cyc     = 0;
  int unsigned lat_min = 1;
  int unsigned lat_jit = 0;

  // reference model: ready queue plus in-flight list with stale marks
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {logic [31:0] pc; bit stale;} fl_t;
  ent_t        mq[$];
  fl_t         mf[$];
  logic [31:0] mpc;
  bit          model_ok = 0;

  logic        o_rv, o_ov;
  logic [31:0] o_ra, o_opc, o_oi;

  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc,
                      input logic mrdy, input logic ordy);
    logic        e_rv, e_ov, fire, rsp, mfire;
    logic [31:0] e_opc, e_oi, faddr, rdata;
    fl_t         f;
    @(negedge clk);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_req_ready  = mrdy;
    out_ready      = ordy;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memf(pend[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    o_rv = mem_req_valid; o_ra = mem_req_addr;
    o_ov = out_valid; o_opc = out_pc; o_oi = out_instr;
    if (model_ok) begin
      e_rv  = !rst && (mq.size() + mf.size() < DEPTH);
      e_ov  = mq.size() > 0;
      e_opc = e_ov ? mq[0].pc : '0;
      e_oi  = e_ov ? mq[0].instr : '0;
      total++;
      if (o_rv !== e_rv || (e_rv && o_ra !== mpc) || o_ov !== e_ov || o_opc !== e_opc || o_oi !== e_oi) begin
        bad++;
        $display("FAIL model cyc=%0d got rv=%b ra=%h ov=%b pc=%h instr=%h want rv=%b ra=%h ov=%b pc=%h instr=%h",
                 cyc, o_rv, o_ra, o_ov, o_opc, o_oi, e_rv, mpc, e_ov, e_opc, e_oi);
      end
    end
    fire  = mem_req_valid && mrdy;
    faddr = mem_req_addr;
    rsp   = mem_rsp_valid;
    rdata = mem_rsp_data;
    @(posedge clk);
    if (rst) pend.delete();
    else begin
      if (rsp) void'(pend.pop_front());
      if (fire) pend.push_back('{addr: faddr, due: cyc + lat_min + $urandom_range(lat_jit, 0)});
    end
    if (rst) begin
      mq.delete(); mf.delete(); mpc = RESET_PC; model_ok = 1;
    end else begin
      mfire = (mq.size() + mf.size() < DEPTH) && mrdy;
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (rsp && mf.size() > 0) begin
        f = mf.pop_front();
        if (!f.stale && !rv) mq.push_back('{pc: f.pc, instr: rdata});
      end
      if (mfire) begin
        mf.push_back('{pc: mpc, stale: 1'b0});
        mpc = mpc + 32'd1;
      end
      if (rv) begin
        mq.delete();
        foreach (mf[i]) mf[i].stale = 1'b1;
        mpc = rpc;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
  endtask

  task automatic check(input string name, input bit ok, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  typedef struct {
    bit          chk;
    logic        rst, rv;
    logic [31:0] rpc;
    logic        mrdy, ordy;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_ov;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit chk, input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic mrdy, input logic ordy, input logic e_rv, input logic [31:0] e_ra,
                              input logic e_ov, input logic [31:0] e_pc);
    tbl.push_back('{chk, rst, rv, rpc, mrdy, ordy, e_rv, e_ra, e_ov, e_pc});
  endfunction

  initial begin
    logic [31:0] exp_i, first_pc, first_i;
    bit          found;
    int          stale_seen;

    // 1-cycle memory streaming
    add(0, 1, 0, 0, 1, 1,  0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1,  0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1,  1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1,  1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1,  1, 2, 1, 0);
    add(1, 0, 0, 0, 1, 1,  1, 3, 1, 1);
    add(1, 0, 0, 0, 1, 1,  1, 4, 1, 2);
    add(1, 0, 0, 0, 1, 1,  1, 5, 1, 3);
    // ID stalled: four credits then stop; release; redirect with pop+response
    add(0, 1, 0, 0, 1, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0,  1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0,  1, 2, 1, 0);
    add(1, 0, 0, 0, 1, 0,  1, 3, 1, 0);
    add(1, 0, 0, 0, 1, 0,  0, 4, 1, 0);
    add(1, 0, 0, 0, 1, 0,  0, 4, 1, 0);
    add(1, 0, 0, 0, 1, 1,  0, 4, 1, 0);
    add(1, 0, 0, 0, 1, 1,  1, 4, 1, 1);
    add(1, 0, 0, 0, 1, 1,  1, 5, 1, 2);
    add(1, 0, 0, 0, 1, 1,  1, 6, 1, 3);
    add(1, 0, 1, 32'h80, 1, 1,  1, 7, 1, 4);
    add(1, 0, 0, 0, 1, 1,  1, 32'h80, 0, 0);
    add(1, 0, 0, 0, 1, 1,  1, 32'h81, 0, 0);
    add(1, 0, 0, 0, 1, 1,  1, 32'h82, 1, 32'h80);
    add(1, 0, 0, 0, 1, 1,  1, 32'h83, 1, 32'h81);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].mrdy, tbl[i].ordy);
      if (tbl[i].chk) begin
        exp_i = tbl[i].e_ov ? memf(tbl[i].e_pc) : 32'h0;
        total++;
        if (o_rv !== tbl[i].e_rv || (tbl[i].e_rv && o_ra !== tbl[i].e_ra) || o_ov !== tbl[i].e_ov ||
            o_opc !== tbl[i].e_pc || o_oi !== exp_i) begin
          bad++;
          $display("FAIL vec%0d got rv=%b ra=%h ov=%b pc=%h instr=%h want rv=%b ra=%h ov=%b pc=%h instr=%h",
                   i, o_rv, o_ra, o_ov, o_opc, o_oi, tbl[i].e_rv, tbl[i].e_ra, tbl[i].e_ov, tbl[i].e_pc, exp_i);
        end
      end
    end

    // 3-cycle memory, two stale requests in flight at redirect
    lat_min = 3;
    do_reset();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h40, 0, 1);
    step(0, 0, 0, 1, 1);
    check("redir_addr", o_rv === 1'b1 && o_ra === 32'h40, o_ra, 32'h40);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 1, 1);
      if (o_ov === 1'b1) begin found = 1; first_pc = o_opc; first_i = o_oi; end
    end
    check("drain_first_pc", found && first_pc === 32'h40, found ? first_pc : 32'hDEAD_DEAD, 32'h40);
    check("drain_first_instr", found && first_i === memf(32'h40), found ? first_i : 32'hDEAD_DEAD, memf(32'h40));

    // back-to-back redirects
    lat_min = 1;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h10, 1, 1);
    step(0, 1, 32'h20, 1, 1);
    found = 0;
    stale_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 1);
      if (o_ov === 1'b1 && o_opc >= 32'h10 && o_opc < 32'h20) stale_seen++;
      if (o_ov === 1'b1 && !found) begin found = 1; first_pc = o_opc; end
    end
    check("b2b_no_0x10", stale_seen == 0, 32'(stale_seen), 32'h0);
    check("b2b_first_pc", found && first_pc === 32'h20, found ? first_pc : 32'hDEAD_DEAD, 32'h20);

    // PC wrap, then reset in the middle of a drain
    do_reset();
    step(0, 1, 32'hFFFF_FFFF, 1, 1);
    step(0, 0, 0, 1, 1);
    check("wrap_top", o_rv === 1'b1 && o_ra === 32'hFFFF_FFFF, o_ra, 32'hFFFF_FFFF);
    step(0, 0, 0, 1, 1);
    check("wrap_zero", o_rv === 1'b1 && o_ra === 32'h0, o_ra, 32'h0);
    lat_min = 3;
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h100, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    check("rst_no_req", o_rv === 1'b0, {31'h0, o_rv}, 32'h0);
    step(0, 0, 0, 1, 1);
    check("rst_req_pc", o_rv === 1'b1 && o_ra === RESET_PC, o_ra, RESET_PC);
    check("rst_empty", o_ov === 1'b0 && o_opc === 32'h0 && o_oi === 32'h0, o_opc, 32'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

    // randomized traffic against the model
    lat_min = 1;
    lat_jit = 3;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic        r_rst, r_rv;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(199, 0) == 0);
      r_rv  = ($urandom_range(19, 0) == 0);
      r_pc  = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC + $urandom_range(3, 0) : $urandom;
      step(r_rst, r_rv, r_pc, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
